// File: rtl/id_issue_pkg.sv
// Shared CPU parameters for the decode/issue stage: widths, instruction
// field layout, opcode encodings and control-word bit positions.
package id_issue_pkg;

    localparam int WORD_DEF       = 32;
    localparam int OPCODE_LEN_DEF = 4;

    // Instruction layout: [31:28] major, [27:24] sub-op, [23:10] 14-bit
    // immediate/offset, [14:10] rs2, [9:5] rs1, [4:0] rs0 / rd.
    localparam int MAJ_LSB     = 28;
    localparam int SUB_LSB     = 24;
    localparam int IMM_LSB     = 10;
    localparam int IMM_W       = 14;
    localparam int REG_FIELD_W = 5;

    typedef enum logic [3:0] {
        MAJ_NOP    = 4'd0,
        MAJ_ALU    = 4'd1,  // rd = rs1 op rs2
        MAJ_ALUI   = 4'd2,  // rd = rs1 op IMM
        MAJ_LI     = 4'd3,  // rd = IMM
        MAJ_LOAD   = 4'd4,  // rd = mem[rs1 + OFFS]
        MAJ_STORE  = 4'd5,  // mem[rs1 + OFFS] = rs0
        MAJ_BRANCH = 4'd6   // if cmp(rs0, rs1) pc += OFFS
    } major_e;

    // ALU opcode used when the instruction carries no explicit sub-op
    // (address generation, load-immediate); CMP opcode when no compare.
    localparam int ALU_ADD  = 0;
    localparam int CMP_NONE = 0;

    // CTRL_EX bit offsets inside the 4-bit EX field.
    localparam int EX_USE_IMM = 0;  // operand B comes from IMM/OFFS
    localparam int EX_BRANCH  = 1;  // compare result steers the PC
    localparam int EX_ZERO_A  = 2;  // operand A forced to zero
    localparam int EX_ILLEGAL = 3;  // undefined major opcode

    // REG_WB source select and MEM command encodings.
    localparam logic [1:0] WB_NONE   = 2'b00;
    localparam logic [1:0] WB_ALU    = 2'b01;
    localparam logic [1:0] WB_MEM    = 2'b10;
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

endpackage

// File: rtl/id_issue_decode.sv
// Combinational instruction decoder: opcodes, control word, immediate and
// offset, destination write-enable and source use-mask.
module id_decode
    import id_issue_pkg::*;
#(
    parameter int WORD       = WORD_DEF,
    parameter int OPCODE_LEN = OPCODE_LEN_DEF
) (
    input  logic [WORD-1:0]                       i_inst,
    output logic [OPCODE_LEN-1:0]                 o_alu_op,
    output logic [OPCODE_LEN-1:0]                 o_cmp_op,
    output logic [7:0]                            o_ctrl,
    output logic [WORD-1:0]                       o_imm,
    output logic [WORD-1:0]                       o_offs,
    output logic                                  o_rd_we,
    output logic [2:0]                            o_use,
    output logic [REG_FIELD_W-1:0]                o_rd,
    output logic [2:0][REG_FIELD_W-1:0]           o_rs
);

    logic [3:0]            w_major;
    logic [OPCODE_LEN-1:0] w_sub;
    logic [WORD-1:0]       w_field_ext;
    logic [1:0]            w_wb;
    logic [1:0]            w_mem;
    logic [3:0]            w_ex;

    assign w_major     = i_inst[MAJ_LSB +: 4];
    assign w_sub       = i_inst[SUB_LSB +: OPCODE_LEN];
    assign w_field_ext = {{(WORD-IMM_W){i_inst[IMM_LSB+IMM_W-1]}}, i_inst[IMM_LSB +: IMM_W]};

    assign o_rd    = i_inst[0 +: REG_FIELD_W];
    assign o_rs[0] = i_inst[0 +: REG_FIELD_W];
    assign o_rs[1] = i_inst[REG_FIELD_W +: REG_FIELD_W];
    assign o_rs[2] = i_inst[2*REG_FIELD_W +: REG_FIELD_W];

    assign o_ctrl  = {w_wb, w_mem, w_ex};
    assign o_rd_we = (w_wb != WB_NONE);

    // Major-opcode decode into control fields, constants and use-mask.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        o_alu_op = OPCODE_LEN'(ALU_ADD);
        o_cmp_op = OPCODE_LEN'(CMP_NONE);
        o_imm    = '0;
        o_offs   = '0;
        o_use    = 3'b000;
        w_wb     = WB_NONE;
        w_mem    = MEM_NONE;
        w_ex     = 4'b0000;
        case (w_major)
            MAJ_NOP: ;
            MAJ_ALU: begin
                o_alu_op = w_sub;
                w_wb     = WB_ALU;
                o_use    = 3'b110;
            end
            MAJ_ALUI: begin
                o_alu_op         = w_sub;
                o_imm            = w_field_ext;
                w_wb             = WB_ALU;
                w_ex[EX_USE_IMM] = 1'b1;
                o_use            = 3'b010;
            end
            MAJ_LI: begin
                o_imm            = w_field_ext;
                w_wb             = WB_ALU;
                w_ex[EX_USE_IMM] = 1'b1;
                w_ex[EX_ZERO_A]  = 1'b1;
            end
            MAJ_LOAD: begin
                o_offs           = w_field_ext;
                w_wb             = WB_MEM;
                w_mem            = MEM_LOAD;
                w_ex[EX_USE_IMM] = 1'b1;
                o_use            = 3'b010;
            end
            MAJ_STORE: begin
                o_offs           = w_field_ext;
                w_mem            = MEM_STORE;
                w_ex[EX_USE_IMM] = 1'b1;
                o_use            = 3'b011;
            end
            MAJ_BRANCH: begin
                o_cmp_op        = w_sub;
                o_offs          = w_field_ext;
                w_ex[EX_BRANCH] = 1'b1;
                o_use           = 3'b011;
            end
            default: w_ex[EX_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: register file with writeback bypass, per-register
// pending scoreboard, one-entry output register with valid/ready handshake,
// flush, and a saturating hazard-stall counter.
module id_issue
    import id_issue_pkg::*;
#(
    parameter int WORD       = WORD_DEF,
    parameter int REG_NUM    = 32,
    parameter int RD_PORTS   = 3,
    parameter int OPCODE_LEN = OPCODE_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD-1:0]            inst,
    input  logic                       wb_en,
    input  logic [$clog2(REG_NUM)-1:0] wb_addr,
    input  logic [WORD-1:0]            wb_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*OPCODE_LEN-1:0]    out_opcode,
    output logic [7:0]                 out_ctrl,
    output logic [RD_PORTS*WORD-1:0]   out_src,
    output logic [2*WORD-1:0]          out_const,
    output logic [$clog2(REG_NUM)-1:0] out_rd,
    output logic                       out_rd_we,
    output logic [31:0]                stall_cnt
);

    localparam int REG_LOG = $clog2(REG_NUM);

    // Decoder outputs
    logic [OPCODE_LEN-1:0]         w_alu_op;
    logic [OPCODE_LEN-1:0]         w_cmp_op;
    logic [7:0]                    w_ctrl;
    logic [WORD-1:0]               w_imm;
    logic [WORD-1:0]               w_offs;
    logic                          w_rd_we;
    logic [2:0]                    w_use;
    logic [REG_FIELD_W-1:0]        w_dec_rd;
    logic [2:0][REG_FIELD_W-1:0]   w_dec_rs;

    // Read ports, hazard and handshake
    logic [REG_LOG-1:0]            w_rs [RD_PORTS];
    logic [RD_PORTS-1:0]           w_wb_hit;
    logic [RD_PORTS-1:0]           w_hz;
    logic [RD_PORTS*WORD-1:0]      w_src_flat;
    logic [REG_LOG-1:0]            w_rd;
    logic                          w_hazard;
    logic                          w_accept;
    logic [REG_NUM-1:0]            w_set;
    logic [REG_NUM-1:0]            w_clr;

    // State
    logic [WORD-1:0]               r_rf [REG_NUM];
    logic [REG_NUM-1:0]            r_pend;
    logic                          r_out_valid;
    logic [2*OPCODE_LEN-1:0]       r_out_opcode;
    logic [7:0]                    r_out_ctrl;
    logic [RD_PORTS*WORD-1:0]      r_out_src;
    logic [2*WORD-1:0]             r_out_const;
    logic [REG_LOG-1:0]            r_out_rd;
    logic                          r_out_rd_we;
    logic [31:0]                   r_stall_cnt;

    id_decode #(
        .WORD       (WORD),
        .OPCODE_LEN (OPCODE_LEN)
    ) u_decode (
        .i_inst   (inst),
        .o_alu_op (w_alu_op),
        .o_cmp_op (w_cmp_op),
        .o_ctrl   (w_ctrl),
        .o_imm    (w_imm),
        .o_offs   (w_offs),
        .o_rd_we  (w_rd_we),
        .o_use    (w_use),
        .o_rd     (w_dec_rd),
        .o_rs     (w_dec_rs)
    );

    assign w_rd = w_dec_rd[REG_LOG-1:0];

    // Per-port operand fetch with same-cycle writeback bypass; r0 is hardwired zero.
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        assign w_rs[p]     = w_dec_rs[p][REG_LOG-1:0];
        assign w_wb_hit[p] = wb_en && (wb_addr == w_rs[p]) && (w_rs[p] != '0);
        assign w_src_flat[p*WORD +: WORD] = (w_rs[p] == '0) ? '0 :
                                            w_wb_hit[p]     ? wb_data :
                                                              r_rf[w_rs[p]];
        // A pending source stalls unless this cycle's writeback resolves it.
        assign w_hz[p] = w_use[p] && r_pend[w_rs[p]] && !w_wb_hit[p];
    end

    assign w_hazard = |w_hz;
    assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush && !rst;
    assign w_accept = in_valid && in_ready;

    // Scoreboard set/clear masks; a set from this cycle's accept wins over any clear.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (wb_en) begin
            w_clr[wb_addr] = 1'b1;
        end
        if (flush && r_out_valid && r_out_rd_we && (r_out_rd != '0)) begin
            w_clr[r_out_rd] = 1'b1;
        end
        if (w_accept && w_rd_we && (w_rd != '0)) begin
            w_set[w_rd] = 1'b1;
        end
    end

    // Pending-bit scoreboard update.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Register file write port; writes to r0 are dropped.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the register file is reset explicitly, so it maps to flops rather than a RAM macro.
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // Output register: load on accept, hold while stalled downstream, drop on consume or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_opcode <= '0;
            r_out_ctrl   <= '0;
            r_out_src    <= '0;
            r_out_const  <= '0;
            r_out_rd     <= '0;
            r_out_rd_we  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_opcode <= {w_alu_op, w_cmp_op};
            r_out_ctrl   <= w_ctrl;
            r_out_src    <= w_src_flat;
            r_out_const  <= {w_imm, w_offs};
            r_out_rd     <= w_rd;
            r_out_rd_we  <= w_rd_we;
        end else if (flush || out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Saturating count of cycles an offered instruction is blocked by a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_opcode = r_out_opcode;
    assign out_ctrl   = r_out_ctrl;
    assign out_src    = r_out_src;
    assign out_const  = r_out_const;
    assign out_rd     = r_out_rd;
    assign out_rd_we  = r_out_rd_we;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_issue.sv
// Bench for id_issue: table of decode vectors plus directed sequences for
// bypass, scoreboard stalls, output hold, flush, r0 and reset mid-stall.
module tb_id_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [7:0]  out_ctrl;
    logic [95:0] out_src;
    logic [63:0] out_const;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    id_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inst       (inst),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_ctrl   (out_ctrl),
        .out_src    (out_src),
        .out_const  (out_const),
        .out_rd     (out_rd),
        .out_rd_we  (out_rd_we),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  opcode;
        logic [7:0]  ctrl;
        logic [31:0] imm;
        logic [31:0] offs;
        logic [4:0]  rd;
        logic        rd_we;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inst, {alu,cmp}, ctrl, imm, offs, rd, rd_we
        vecs[0] = '{32'h1300_0824, 8'h30, 8'h40, 32'h0000_0000, 32'h0000_0000, 5'd4,  1'b1}; // ALU sub3
        vecs[1] = '{32'h25FF_FC46, 8'h50, 8'h41, 32'hFFFF_FFFF, 32'h0000_0000, 5'd6,  1'b1}; // ALUI imm=-1
        vecs[2] = '{32'h306A_F009, 8'h00, 8'h45, 32'h0000_1ABC, 32'h0000_0000, 5'd9,  1'b1}; // LI
        vecs[3] = '{32'h4080_006A, 8'h00, 8'h91, 32'h0000_0000, 32'hFFFF_E000, 5'd10, 1'b1}; // LOAD min offs
        vecs[4] = '{32'h5000_418B, 8'h00, 8'h21, 32'h0000_0000, 32'h0000_0010, 5'd11, 1'b0}; // STORE
        vecs[5] = '{32'h62FF_F822, 8'h02, 8'h02, 32'h0000_0000, 32'hFFFF_FFFE, 5'd2,  1'b0}; // BRANCH
        vecs[6] = '{32'h0ABC_DEF1, 8'h00, 8'h00, 32'h0000_0000, 32'h0000_0000, 5'd17, 1'b0}; // NOP
        vecs[7] = '{32'hF000_0003, 8'h00, 8'h08, 32'h0000_0000, 32'h0000_0000, 5'd3,  1'b0}; // illegal

        rst = 1'b1; in_valid = 1'b0; inst = '0; wb_en = 1'b0; wb_addr = '0;
        wb_data = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_in_ready",  in_ready,   0);
        check("rst_out_valid", out_valid,  0);
        check("rst_stall",     stall_cnt,  0);
        check("rst_src",       out_src,    0);
        check("rst_const",     out_const,  0);
        check("rst_ctrl",      out_ctrl,   0);
        check("rst_rd_we",     out_rd_we,  0);
        tick();
        rst = 1'b0;

        // Decode table
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            inst     = vecs[i].inst;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            inst     = '0;
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i),  out_valid,  1);
            check($sformatf("tbl%0d_opcode", i), out_opcode, vecs[i].opcode);
            check($sformatf("tbl%0d_ctrl", i),   out_ctrl,   vecs[i].ctrl);
            check($sformatf("tbl%0d_const", i),  out_const,  {vecs[i].imm, vecs[i].offs});
            check($sformatf("tbl%0d_rd", i),     out_rd,     vecs[i].rd);
            check($sformatf("tbl%0d_rd_we", i),  out_rd_we,  vecs[i].rd_we);
            tick();
        end

        // Fresh start for the directed sequences
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Writeback then read r5 through port 0
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        tick();
        wb_en = 1'b0;
        in_valid = 1'b1; inst = 32'h5000_0005;
        @(negedge clk);
        check("r5_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("r5_src0", out_src[31:0], 32'h0000_1234);
        tick();

        // Same-cycle writeback bypass on port 0
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_0055;
        in_valid = 1'b1; inst = 32'h5000_0006;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("bypass_src0", out_src[31:0], 32'h0000_0055);
        tick();

        // Writer r3 then reader rs1=3: stall until wb r3 releases it
        in_valid = 1'b1; inst = 32'h3000_0003;
        tick();
        inst = 32'h1000_0068;
        @(negedge clk);
        check("raw_stall_ready", in_ready, 0);
        tick(); tick(); tick();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_00AA;
        @(negedge clk);
        check("raw_stall_cnt", stall_cnt, 3);
        check("raw_release_ready", in_ready, 1);
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("raw_src1", out_src[63:32], 32'h0000_00AA);
        check("raw_rd", out_rd, 8);
        check("raw_cnt_after", stall_cnt, 3);
        tick();

        // Set wins over same-cycle writeback clear of the same register
        in_valid = 1'b1; inst = 32'h3000_000C;
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_0099;
        @(negedge clk);
        check("setwin_accept", in_ready, 1);
        tick();
        wb_en = 1'b0; inst = 32'h1000_0181;
        @(negedge clk);
        check("setwin_stall", in_ready, 0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_005A;
        @(negedge clk);
        check("setwin_release", in_ready, 1);
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("setwin_src1", out_src[63:32], 32'h0000_005A);
        check("setwin_cnt", stall_cnt, 4);
        tick();

        // Hold: out_ready low for 4 cycles keeps outputs stable
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'h3001_DC0D;
        @(negedge clk);
        check("hold_accept", in_ready, 1);
        tick();
        inst = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", k), out_valid, 1);
            check($sformatf("hold%0d_const", k), out_const, {32'h0000_0077, 32'h0});
            check($sformatf("hold%0d_rd", k),    out_rd, 13);
            check($sformatf("hold%0d_ready", k), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("hold_next_valid", out_valid, 1);
        check("hold_next_ctrl", out_ctrl, 0);
        check("hold_next_rd", out_rd, 0);
        tick();

        // Flush a held writer of r7; its pending bit must clear
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'h3000_0007;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_ready", in_ready, 0);
        tick();
        flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; inst = 32'h1000_00E1;
        @(negedge clk);
        check("flush_valid", out_valid, 0);
        check("flush_reader_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_reader_valid", out_valid, 1);
        check("flush_no_stall", stall_cnt, 4);
        tick();

        // r0: writes ignored, bypass ignored, no pending bit
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_FFFF;
        tick();
        in_valid = 1'b1; inst = 32'h5000_0000;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("r0_src", out_src[63:0], 64'h0);
        tick();
        in_valid = 1'b1; inst = 32'h3000_0000;
        tick();
        inst = 32'h5000_0000;
        @(negedge clk);
        check("r0_no_pend", in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();

        // Reset during a hazard stall
        in_valid = 1'b1; inst = 32'h3000_0014;
        tick();
        inst = 32'h1000_0282;
        tick(); tick();
        @(negedge clk);
        check("pre_rst_cnt", stall_cnt, 6);
        check("pre_rst_rd", out_rd, 20);
        rst = 1'b1;
        #1;
        check("mid_rst_cnt", stall_cnt, 0);
        check("mid_rst_rd", out_rd, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_opcode", out_opcode, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_cnt", stall_cnt, 0);
        tick();
        in_valid = 1'b1; inst = 32'h5000_0005;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_rf", out_src[31:0], 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
